// File: rtl/hilo_acc_bank_pkg.sv
// ---------------------------------------------------------------------------
// hilo_pkg -- shared types for the HI/LO accumulator bank.
//
// Contents:
//   wmode_e  : command encoding on wmode (WR, WR_HI, WR_LO, MADD, MSUB,
//              MADDU, MSUBU, CLR)
//   stage_t  : control part of the accumulate stage register
//              (valid, bank, mode)
//   is_acc() : true for the four accumulate commands
//   is_sub() : true for MSUB / MSUBU
//
// The product operand of the stage register is held beside stage_t in the
// top level, because its width follows the DW parameter of each instance.
// The bank field is sized for the largest supported bank count (4).
// ---------------------------------------------------------------------------
package hilo_pkg;

  localparam int HILO_MAX_BANK = 4;
  localparam int HILO_BANK_W   = 2;

  typedef enum logic [2:0] {
    WM_WR    = 3'd0,
    WM_WR_HI = 3'd1,
    WM_WR_LO = 3'd2,
    WM_MADD  = 3'd3,
    WM_MSUB  = 3'd4,
    WM_MADDU = 3'd5,
    WM_MSUBU = 3'd6,
    WM_CLR   = 3'd7
  } wmode_e;

  typedef struct packed {
    logic                   valid;
    logic [HILO_BANK_W-1:0] bank;
    wmode_e                 mode;
  } stage_t;

  function automatic logic is_acc(input wmode_e m);
    return (m == WM_MADD) || (m == WM_MSUB) || (m == WM_MADDU) || (m == WM_MSUBU);
  endfunction

  function automatic logic is_sub(input wmode_e m);
    return (m == WM_MSUB) || (m == WM_MSUBU);
  endfunction

endpackage

// File: rtl/hilo_acc_bank_alu.sv
// ---------------------------------------------------------------------------
// hilo_acc_alu -- combinational multiply-accumulate/subtract datapath.
//
// Ports:
//   acc    in  2*DW  current {HI,LO} of the target bank
//   prod   in  2*DW  product operand captured from EX
//   mode   in  wmode_e  accumulate command (MADD/MSUB/MADDU/MSUBU)
//   result out 2*DW  new {HI,LO}
//   sat    out 1     clamping occurred (only with HILO_SAT_EN)
//
// Build option: HILO_SAT_EN -- when defined the result saturates (signed
// range for MADD/MSUB, unsigned range for MADDU/MSUBU); otherwise every mode
// wraps modulo 2^(2*DW) and the sat output does not exist.
// ---------------------------------------------------------------------------
module hilo_acc_alu
  import hilo_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2*DW-1:0] acc,
  input  logic [2*DW-1:0] prod,
  input  wmode_e          mode,
  output logic [2*DW-1:0] result
`ifdef HILO_SAT_EN
  ,
  output logic            sat
`endif
);

  localparam int PW = 2 * DW;

  logic sub;
  assign sub = is_sub(mode);

`ifdef HILO_SAT_EN
  // One extra bit captures carry-out (add) or borrow (subtract).
  logic [PW:0] raw;
  logic        ovf_signed;

  assign raw = sub ? ({1'b0, acc} - {1'b0, prod}) : ({1'b0, acc} + {1'b0, prod});

  // Signed overflow: the result sign disagrees with acc while the operand
  // signs make overflow possible (same signs for add, opposite for sub).
  // The direction of overflow always follows the sign of acc.
  assign ovf_signed = (sub ? (acc[PW-1] != prod[PW-1]) : (acc[PW-1] == prod[PW-1]))
                      && (raw[PW-1] != acc[PW-1]);

  always_comb begin
    result = raw[PW-1:0];
    sat    = 1'b0;
    case (mode)
      WM_MADD, WM_MSUB: begin
        if (ovf_signed) begin
          sat    = 1'b1;
          result = acc[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        end
      end
      WM_MADDU: begin
        if (raw[PW]) begin
          sat    = 1'b1;
          result = '1;
        end
      end
      WM_MSUBU: begin
        if (raw[PW]) begin
          sat    = 1'b1;
          result = '0;
        end
      end
      default: ;
    endcase
  end
`else
  assign result = sub ? (acc - prod) : (acc + prod);
`endif

endmodule

// File: rtl/hilo_acc_bank.sv
// ---------------------------------------------------------------------------
// hilo_acc_bank -- NBANK independent HI/LO register pairs with whole/half
// writes, bank clear and a two-edge multiply-accumulate path.
//
// Parameters: DW (register width), NBANK (1..4 pairs), BW (derived index
// width).
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous reset, active low
//   we       command valid (ignored while busy_o)
//   wmode    command (see hilo_pkg::wmode_e)
//   wbank    target bank of the command
//   hi_i     HI write data (WR, WR_HI)
//   lo_i     LO write data (WR, WR_LO)
//   prod_i   2*DW product operand for accumulate commands
//   rbank    read bank select
//   hi_o     HI of rbank (0 for an out-of-range rbank)
//   lo_o     LO of rbank (0 for an out-of-range rbank)
//   busy_o   accumulate in flight; upstream holds its command
//   stale_o  busy_o and rbank is the bank being accumulated
//   sat_o    one-cycle saturation pulse (only with HILO_SAT_EN)
//
// Build option: HILO_SAT_EN enables saturating accumulate and sat_o.
//
// Accumulate: edge 0 captures bank/mode/prod into the stage register;
// edge 1 reads {HI,LO} of that bank, combines it with prod and writes back.
// No other write is accepted while the stage is full, so the operand read
// at edge 1 is the same value that was current at edge 0.
// ---------------------------------------------------------------------------
module hilo_acc_bank
  import hilo_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int NBANK = 1,
  localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [2:0]      wmode,
  input  logic [BW-1:0]   wbank,
  input  logic [DW-1:0]   hi_i,
  input  logic [DW-1:0]   lo_i,
  input  logic [2*DW-1:0] prod_i,
  input  logic [BW-1:0]   rbank,
  output logic [DW-1:0]   hi_o,
  output logic [DW-1:0]   lo_o,
  output logic            busy_o,
  output logic            stale_o
`ifdef HILO_SAT_EN
  ,
  output logic            sat_o
`endif
);

  // NBANK fits in BW+1 bits for every legal bank count.
  localparam logic [BW:0] NBANK_W = (BW + 1)'(NBANK);

  wmode_e          cmd_mode;
  logic            wbank_ok;
  logic            accept;
  logic            acc_start;
  logic            plain_wr;
  logic            wb;

  stage_t          stage_reg;
  logic [2*DW-1:0] prod_reg;

  logic [DW-1:0]   hi_bank [NBANK];
  logic [DW-1:0]   lo_bank [NBANK];
  logic [DW-1:0]   acc_hi;
  logic [DW-1:0]   acc_lo;
  logic [2*DW-1:0] acc_result;

  assign cmd_mode  = wmode_e'(wmode);
  assign wbank_ok  = ({1'b0, wbank} < NBANK_W);
  // Out-of-range banks are never accepted, so they can neither write nor
  // start an accumulate (and so never make stale_o match).
  assign accept    = we && !stage_reg.valid && wbank_ok;
  assign acc_start = accept && is_acc(cmd_mode);
  assign plain_wr  = accept && !is_acc(cmd_mode);
  assign wb        = stage_reg.valid;

  // Accumulate stage register: full for exactly one cycle per accepted op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_reg <= '0;
      prod_reg  <= '0;
    end else if (acc_start) begin
      stage_reg <= '{valid: 1'b1, bank: HILO_BANK_W'(wbank), mode: cmd_mode};
      prod_reg  <= prod_i;
    end else if (stage_reg.valid) begin
      stage_reg.valid <= 1'b0;
    end
  end

  // Operand fetch for the in-flight bank.
  always_comb begin
    acc_hi = '0;
    acc_lo = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (stage_reg.bank == HILO_BANK_W'(i)) begin
        acc_hi = hi_bank[i];
        acc_lo = lo_bank[i];
      end
    end
  end

`ifdef HILO_SAT_EN
  logic acc_sat;
  logic sat_reg;

  hilo_acc_alu #(.DW(DW)) u_alu (
    .acc    ({acc_hi, acc_lo}),
    .prod   (prod_reg),
    .mode   (stage_reg.mode),
    .result (acc_result),
    .sat    (acc_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_reg <= 1'b0;
    end else begin
      sat_reg <= wb && acc_sat;
    end
  end

  assign sat_o = sat_reg;
`else
  hilo_acc_alu #(.DW(DW)) u_alu (
    .acc    ({acc_hi, acc_lo}),
    .prod   (prod_reg),
    .mode   (stage_reg.mode),
    .result (acc_result)
  );
`endif

  // Bank storage: one HI/LO pair per generate iteration.
  genvar gi;
  for (gi = 0; gi < NBANK; gi++) begin : g_bank
    logic [DW-1:0] hi_reg;
    logic [DW-1:0] lo_reg;
    logic          wr_hit;
    logic          wb_hit;

    assign wr_hit = plain_wr && (wbank == BW'(gi));
    assign wb_hit = wb && (stage_reg.bank == HILO_BANK_W'(gi));

    // wb_hit and wr_hit are mutually exclusive: plain writes are refused
    // while the stage is full.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hi_reg <= '0;
        lo_reg <= '0;
      end else if (wb_hit) begin
        hi_reg <= acc_result[2*DW-1:DW];
        lo_reg <= acc_result[DW-1:0];
      end else if (wr_hit) begin
        case (cmd_mode)
          WM_WR: begin
            hi_reg <= hi_i;
            lo_reg <= lo_i;
          end
          WM_WR_HI: hi_reg <= hi_i;
          WM_WR_LO: lo_reg <= lo_i;
          WM_CLR: begin
            hi_reg <= '0;
            lo_reg <= '0;
          end
          default: ;
        endcase
      end
    end

    assign hi_bank[gi] = hi_reg;
    assign lo_bank[gi] = lo_reg;
  end

  // Read port: an rbank with no matching bank falls through to zero.
  always_comb begin
    hi_o = '0;
    lo_o = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (rbank == BW'(i)) begin
        hi_o = hi_bank[i];
        lo_o = lo_bank[i];
      end
    end
  end

  assign busy_o  = stage_reg.valid;
  assign stale_o = stage_reg.valid && (stage_reg.bank == HILO_BANK_W'(rbank));

endmodule

// File: tb/tb_hilo_acc_bank.sv
// ---------------------------------------------------------------------------
// tb_hilo_acc_bank -- self-checking bench for hilo_acc_bank (DW=32, NBANK=3).
// The reference keeps each bank as one 64-bit {HI,LO} value and computes
// accumulates with plain wide arithmetic. Build with HILO_SAT_EN defined to
// exercise the saturating variant and sat_o.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hilo_acc_bank;
  import hilo_pkg::*;

  localparam int DW    = 32;
  localparam int NBANK = 3;
  localparam int BW    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            we = 1'b0;
  logic [2:0]      wmode = 3'd0;
  logic [BW-1:0]   wbank = '0;
  logic [DW-1:0]   hi_i = '0;
  logic [DW-1:0]   lo_i = '0;
  logic [2*DW-1:0] prod_i = '0;
  logic [BW-1:0]   rbank = '0;
  logic [DW-1:0]   hi_o;
  logic [DW-1:0]   lo_o;
  logic            busy_o;
  logic            stale_o;
`ifdef HILO_SAT_EN
  logic            sat_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic [63:0] model [NBANK];

  hilo_acc_bank #(.DW(DW), .NBANK(NBANK)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wmode   (wmode),
    .wbank   (wbank),
    .hi_i    (hi_i),
    .lo_i    (lo_i),
    .prod_i  (prod_i),
    .rbank   (rbank),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .busy_o  (busy_o),
    .stale_o (stale_o)
`ifdef HILO_SAT_EN
    ,
    .sat_o   (sat_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference accumulate: exact wide arithmetic, then clamp to range.
  function automatic logic [63:0] acc_ref(input logic [2:0] m, input logic [63:0] a,
                                          input logic [63:0] p, output logic s);
    logic [65:0] ur;
    logic        add;
    add = (m == WM_MADD) || (m == WM_MADDU);
    ur  = add ? ({2'b00, a} + {2'b00, p}) : ({2'b00, a} - {2'b00, p});
    s   = 1'b0;
    acc_ref = ur[63:0];
`ifdef HILO_SAT_EN
    begin
      logic signed [65:0] sr;
      sr = add ? ($signed({{2{a[63]}}, a}) + $signed({{2{p[63]}}, p}))
               : ($signed({{2{a[63]}}, a}) - $signed({{2{p[63]}}, p}));
      if (m == WM_MADD || m == WM_MSUB) begin
        if (sr > 66'sh0_7FFF_FFFF_FFFF_FFFF) begin
          s = 1'b1; acc_ref = 64'h7FFF_FFFF_FFFF_FFFF;
        end else if (sr < 66'sh3_8000_0000_0000_0000) begin
          s = 1'b1; acc_ref = 64'h8000_0000_0000_0000;
        end
      end else if (m == WM_MADDU && ur > 66'h0_FFFF_FFFF_FFFF_FFFF) begin
        s = 1'b1; acc_ref = 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (m == WM_MSUBU && a < p) begin
        s = 1'b1; acc_ref = 64'h0;
      end
    end
`endif
  endfunction

  // Sweeps rbank over every index including the out-of-range one.
  task automatic read_all(input string tag);
    for (int b = 0; b < 4; b++) begin
      rbank = BW'(b);
      #1;
      check($sformatf("%s_rd%0d", tag, b), {hi_o, lo_o}, (b < NBANK) ? model[b] : 64'h0);
    end
  endtask

  // Presents one command for one edge; for an accepted accumulate it also
  // checks the busy cycle and waits through writeback.
  task automatic do_cmd(input logic [2:0] m, input int b, input logic [31:0] h,
                        input logic [31:0] l, input logic [63:0] p, input string tag);
    logic        s;
    logic [63:0] r;
    logic        is_a;
    logic        ok;
    is_a   = (m >= 3'd3) && (m <= 3'd6);
    ok     = (b < NBANK);
    we     = 1'b1; wmode = m; wbank = BW'(b); hi_i = h; lo_i = l; prod_i = p;
    @(posedge clk); #1;
    we = 1'b0;
    if (ok && is_a) begin
      check({tag, "_busy1"}, 64'(busy_o), 64'h1);
      rbank = BW'((b + 1) % 4); #1;
      check({tag, "_stale_other"}, 64'(stale_o), 64'h0);
      rbank = BW'(b); #1;
      check({tag, "_stale"}, 64'(stale_o), 64'h1);
      check({tag, "_preupd"}, {hi_o, lo_o}, model[b]);
      r = acc_ref(m, model[b], p, s);
      @(posedge clk); #1;
      model[b] = r;
      check({tag, "_busy0"}, 64'(busy_o), 64'h0);
`ifdef HILO_SAT_EN
      check({tag, "_sat"}, 64'(sat_o), 64'(s));
`endif
    end else begin
      if (ok) begin
        case (m)
          3'd0: model[b] = {h, l};
          3'd1: model[b][63:32] = h;
          3'd2: model[b][31:0] = l;
          3'd7: model[b] = 64'h0;
          default: ;
        endcase
      end
      check({tag, "_nobusy"}, 64'(busy_o), 64'h0);
    end
  endtask

  initial begin
    logic        s;
    logic [63:0] r;
    for (int b = 0; b < NBANK; b++) model[b] = 64'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    read_all("reset");
    check("reset_busy", 64'(busy_o), 64'h0);
    check("reset_stale", 64'(stale_o), 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Partial writes.
    do_cmd(WM_WR, 1, 32'h1111_1111, 32'h2222_2222, 64'h0, "wr1");
    do_cmd(WM_WR_HI, 1, 32'hAAAA_AAAA, 32'h5555_5555, 64'h0, "wrhi1");
    read_all("partial");
    do_cmd(WM_WR_LO, 1, 32'h0, 32'h3333_3333, 64'h0, "wrlo1");
    read_all("partial_lo");

    // MADD wrap (in the saturating build this MADD is -1+1 and does not clamp).
    do_cmd(WM_WR, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, "wr0");
    do_cmd(WM_MADD, 0, 32'h0, 32'h0, 64'h1, "madd_wrap");
    read_all("madd_wrap");
    check("madd_wrap_zero", {hi_o, lo_o}, 64'h0);

    // Stall: a WR held through the busy cycle lands one edge later.
    do_cmd(WM_WR, 2, 32'h0000_0010, 32'h0000_0100, 64'h0, "wr2");
    we = 1'b1; wmode = WM_MSUB; wbank = 2'd2; prod_i = 64'h0000_0001_0000_0001;
    @(posedge clk); #1;
    wmode = WM_WR; hi_i = 32'hDEAD_BEEF; lo_i = 32'hCAFE_F00D;
    check("stall_busy", 64'(busy_o), 64'h1);
    r = acc_ref(WM_MSUB, model[2], 64'h0000_0001_0000_0001, s);
    @(posedge clk); #1;
    model[2] = r;
    check("stall_busy0", 64'(busy_o), 64'h0);
    rbank = 2'd2; #1;
    check("stall_msub", {hi_o, lo_o}, 64'h0000_000F_0000_00FF);
    @(posedge clk); #1;
    we = 1'b0;
    model[2] = {32'hDEAD_BEEF, 32'hCAFE_F00D};
    read_all("stall_final");

    // Out-of-range bank: neither a write nor an accumulate may take effect.
    do_cmd(WM_WR, 3, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0, "oor_wr");
    do_cmd(WM_MADD, 3, 32'h0, 32'h0, 64'h5, "oor_madd");
    read_all("oor");
    do_cmd(WM_CLR, 1, 32'h0, 32'h0, 64'h0, "clr1");
    read_all("clr");

`ifdef HILO_SAT_EN
    do_cmd(WM_WR, 2, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 64'h0, "sat_wr");
    do_cmd(WM_MADD, 2, 32'h0, 32'h0, 64'h20, "sat_madd");
    check("sat_madd_val", model[2], 64'h7FFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    check("sat_pulse_end", 64'(sat_o), 64'h0);
    do_cmd(WM_WR, 0, 32'h0, 32'h5, 64'h0, "satu_wr");
    do_cmd(WM_MSUBU, 0, 32'h0, 32'h0, 64'h6, "sat_msubu");
    read_all("sat");
`endif

    // Randomised commands against the reference.
    for (int n = 0; n < 80; n++) begin
      logic [2:0]  m;
      logic [63:0] p;
      m = 3'($urandom_range(0, 7));
      p = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 255))
                                      : {$urandom(), $urandom()};
      do_cmd(m, $urandom_range(0, 3), $urandom(), $urandom(), p, $sformatf("rnd%0d", n));
      read_all($sformatf("rnd%0d", n));
    end

    // Reset in the middle of an accumulate.
    do_cmd(WM_WR, 1, 32'h0000_0001, 32'h0000_0002, 64'h0, "pre_rst");
    we = 1'b1; wmode = WM_MADD; wbank = 2'd1; prod_i = 64'h10;
    @(posedge clk); #1;
    we = 1'b0;
    check("midrst_busy", 64'(busy_o), 64'h1);
    rst = 1'b0; #1;
    for (int b = 0; b < NBANK; b++) model[b] = 64'h0;
    check("midrst_busy0", 64'(busy_o), 64'h0);
    rbank = 2'd1; #1;
    check("midrst_stale0", 64'(stale_o), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 64'(busy_o), 64'h0);
    read_all("post_rst");
    rbank = 2'd1; #1;
    check("post_rst_stale", 64'(stale_o), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_acc_bank.md
Name: hilo_acc_bank

Overview:
Parametrised successor to the single HI/LO pair. Holds NBANK independent HI/LO register pairs of width DW, each addressable for read and write. Adds per-half writes, bank clear, and a 2-cycle multiply-accumulate/subtract path (MADD/MSUB family) fed with a precomputed 2*DW product from EX. Sits between EX/MEM writeback and the ID/EX HI/LO read path.

Parameters:
DW, 32, width of each HI and LO register
NBANK, 1, number of HI/LO pairs (1..4)
BW, (NBANK>1)?$clog2(NBANK):1, bank index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
we  in  1  command valid; ignored while busy_o=1
wmode  in  3  command: 0 WR, 1 WR_HI, 2 WR_LO, 3 MADD, 4 MSUB, 5 MADDU, 6 MSUBU, 7 CLR
wbank  in  BW  target bank of command
hi_i  in  DW  HI write data (WR, WR_HI)
lo_i  in  DW  LO write data (WR, WR_LO)
prod_i  in  2*DW  product operand for MADD/MSUB family
rbank  in  BW  read bank select
hi_o  out  DW  HI of rbank, combinational mux of stored state
lo_o  out  DW  LO of rbank, combinational mux of stored state
busy_o  out  1  accumulate in flight; upstream must hold its command
stale_o  out  1  busy_o=1 and rbank equals in-flight bank (read value is pre-update)

Behaviour:
- Reset (rst=0, async): all banks HI=LO=0; pipeline stage empty; busy_o=0, stale_o=0; hi_o/lo_o=0 for any rbank.
- Reset mid-accumulate: in-flight op discarded; all banks zero on release.
- Plain commands (WR, WR_HI, WR_LO, CLR) with we=1, busy_o=0: bank updated at that clk edge; visible on hi_o/lo_o in the next cycle. WR_HI leaves LO unchanged; WR_LO leaves HI unchanged; CLR zeroes both halves. busy_o is not asserted.
- Accumulate commands (3..6) with we=1, busy_o=0:
  - Edge 0: prod_i, wbank and mode captured into the stage register; busy_o=1 from the next cycle.
  - Edge 1: acc={HI,LO} of the captured bank; result = acc+prod (MADD/MADDU) or acc-prod (MSUB/MSUBU), modulo 2^(2*DW); HI=result[2DW-1:DW], LO=result[DW-1:0]; stage cleared; busy_o=0 from the next cycle.
  - Total latency: 2 edges from accept to visible result. Throughput: one accumulate per 2 cycles.
- we=1 while busy_o=1: command not accepted and not queued; state unchanged. Upstream holds the command and re-presents it once busy_o=0.
- Bank state is frozen while busy_o=1 (no other write can be accepted), so accumulate reads a stable operand.
- wbank/rbank >= NBANK: write ignored; read returns 0; stale_o=0.
- stale_o is combinational: busy_o and (rbank == captured bank).
- Signed vs unsigned modes differ only when HILO_SAT_EN is defined.

Optional Feature:
Macro HILO_SAT_EN.
- Defined: accumulate saturates.
  - MADD/MSUB: the 2*DW result is treated as two's complement; positive overflow clamps to 0x7FF..F, negative to 0x800..0.
  - MADDU: clamps to all-ones on carry-out.
  - MSUBU: clamps to 0 on borrow.
  - Adds output sat_o (1 bit), pulsed for one cycle coincident with the writeback edge when clamping occurred; reset 0.
- Undefined: all accumulate modes wrap modulo 2^(2*DW); no sat_o port.

Decomposition:
- Shared package hilo_pkg holds:
  - the wmode enum (WR, WR_HI, WR_LO, MADD, MSUB, MADDU, MSUBU, CLR);
  - the stage-register struct type (valid, bank, mode, prod).
- Add the HILO_* defines alongside RstEnable/WriteEnable in defines.v.
- One natural sub-module: hilo_acc_alu, combinational. Takes acc, prod and mode; returns the result and the saturation flag.

Test Plan:
- Reset: drive rst=0 mid-MADD with NBANK=4 -> every bank reads 0; busy_o=0; stale_o=0 after release.
- Partial writes: WR bank1 hi=0x11111111 lo=0x22222222, then WR_HI bank1 0xAAAAAAAA -> bank1 reads {0xAAAAAAAA, 0x22222222}; bank0 stays 0.
- MADD wrap: bank0={0xFFFFFFFF,0xFFFFFFFF}, MADD prod=1 -> busy_o=1 for one cycle, then bank0={0,0}; stale_o=1 during busy when rbank=0.
- Stall: issue MSUB, then hold WR with we=1 during busy -> WR ignored while busy_o=1; applied the cycle after busy_o drops; final value = WR data.
- Saturation (HILO_SAT_EN): bank2={0x7FFFFFFF,0xFFFFFFF0}, MADD prod=0x20 -> {0x7FFFFFFF,0xFFFFFFFF}, sat_o=1 for one cycle. MSUBU on {0,5} with prod 6 -> {0,0}, sat_o=1.
- Out-of-range: NBANK=3, WR wbank=3 -> no bank changes; rbank=3 reads 0.
